// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: baud tick generator, synchroniser, majority-vote framing FSM,
// show-ahead FIFO carrying per-entry error flags, break detection and RTS flow control.
module uart_rx_os #(
    parameter int OSR        = 16,
    parameter int DIV_W      = 16,
    parameter int DEPTH      = 16,
    parameter int RTS_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [DIV_W-1:0]           baud_div,
    input  logic [3:0]                 cfg_data_bits,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop2,
    input  logic                       rx,
    output logic                       rts_n,
    output logic [11:0]                rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overrun,
    input  logic                       clr_err
);
    localparam int SW = $clog2(OSR);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] S_A   = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] S_B   = SW'(OSR / 2);
    localparam logic [SW-1:0] S_DEC = SW'(OSR / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OSR - 1);

    // IDLE wait start edge | START vet start bit | DATA shift | PARITY check | STOP check + push
    // BRK_WAIT hold after a break until the line returns high
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3,
                           STOP = 3'd4, BRK_WAIT = 3'd5;

    logic [DIV_W-1:0] tcnt, div_q, div_in;
    logic             os_tick;

    assign div_in  = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign os_tick = (tcnt == div_q - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            div_q <= div_in;
        end else if (os_tick) begin
            tcnt  <= '0;
            div_q <= div_in;
        end else begin
            tcnt <= tcnt + DIV_W'(1);
        end
    end

    logic [1:0] sync;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    logic [2:0]    state;
    logic [SW-1:0] s, s_nxt;
    logic [1:0]    samp;
    logic [8:0]    data;
    logic [3:0]    bit_idx, nb_q, nb_cfg;
    logic [1:0]    par_q;
    logic          stop2_q, stop_idx, par_bit, par_err, frm_err, brk_q;
    logic          maj, par_en, last_stop, brk_cand, brk_now, push;
    logic [11:0]   din;

    assign s_nxt     = (s == S_END) ? '0 : s + SW'(1);
    assign maj       = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
    assign par_en    = par_q[0] ^ par_q[1];
    assign last_stop = ~stop2_q | stop_idx;
    assign brk_cand  = (data == '0) & ~(par_en & par_bit);
    assign brk_now   = stop_idx ? brk_q : (brk_cand & ~maj);
    assign push      = enable & os_tick & (state == STOP) & (s == S_DEC) & last_stop;
    assign din       = {brk_now, frm_err | ~maj, par_err, data};
    assign nb_cfg    = (cfg_data_bits < 4'd5) ? 4'd5 :
                       (cfg_data_bits > 4'd9) ? 4'd9 : cfg_data_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            samp     <= 2'b11;
            data     <= '0;
            bit_idx  <= '0;
            nb_q     <= 4'd8;
            par_q    <= 2'b00;
            stop2_q  <= 1'b0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            brk_q    <= 1'b0;
        end else if (!enable) begin
            state <= IDLE;
            s     <= '0;
        end else if (os_tick) begin
            if (state != IDLE && state != BRK_WAIT && (s == S_A || s == S_B))
                samp <= {samp[0], rx_s};
            case (state)
                IDLE: if (!rx_s) begin
                    s     <= '0;
                    state <= START;
                end
                START: begin
                    s <= s_nxt;
                    if (s == S_DEC && maj) begin
                        state <= IDLE;
                        s     <= '0;
                    end else if (s == S_END) begin
                        state    <= DATA;
                        nb_q     <= nb_cfg;
                        par_q    <= cfg_parity;
                        stop2_q  <= cfg_stop2;
                        bit_idx  <= '0;
                        data     <= '0;
                        par_bit  <= 1'b0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                        brk_q    <= 1'b0;
                        stop_idx <= 1'b0;
                    end
                end
                DATA: begin
                    s <= s_nxt;
                    if (s == S_DEC) data[bit_idx] <= maj;
                    if (s == S_END) begin
                        if (bit_idx == nb_q - 4'd1) state <= par_en ? PARITY : STOP;
                        else                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY: begin
                    s <= s_nxt;
                    if (s == S_DEC) begin
                        par_bit <= maj;
                        par_err <= (^data) ^ maj ^ par_q[1];
                    end
                    if (s == S_END) state <= STOP;
                end
                STOP: begin
                    s <= s_nxt;
                    if (s == S_DEC) begin
                        if (last_stop) begin
                            state <= brk_now ? BRK_WAIT : IDLE;
                            s     <= '0;
                        end else begin
                            frm_err <= ~maj;
                            brk_q   <= brk_cand & ~maj;
                        end
                    end else if (s == S_END) begin
                        stop_idx <= 1'b1;
                    end
                end
                BRK_WAIT: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [11:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr, rptr_n;
    logic [LW-1:0] level_n;
    logic          full, pop, wr;

    assign full    = (level == LW'(DEPTH));
    assign pop     = rd_valid & rd_ready;
    assign wr      = push & (~full | pop);
    assign rptr_n  = pop ? rptr + PW'(1) : rptr;
    assign level_n = level + LW'(wr) - LW'(pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overrun  <= 1'b0;
            rts_n    <= 1'b1;
        end else begin
            if (wr) wptr <= wptr + PW'(1);
            rptr     <= rptr_n;
            level    <= level_n;
            rd_valid <= (level_n != '0);
            // when the new head is the entry being written this cycle, bypass the array
            if (wr && level == LW'(pop)) rd_data <= din;
            else if (level_n != '0)      rd_data <= mem[rptr_n];
            if (push && full && !pop) overrun <= 1'b1;
            else if (clr_err)         overrun <= 1'b0;
            rts_n <= (level_n >= LW'(RTS_THRESH));
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: table of frames plus hand-written glitch, break,
// overrun/RTS and mid-frame reset sequences, with a queue scoreboard for FIFO contents.
module tb_uart_rx_os;
    localparam int DIV = 2;
    localparam int OSR = 16;
    localparam int BIT = DIV * OSR;
    localparam int NV  = 11;

    logic        clk = 1'b0;
    logic        rst, enable, rx, rd_ready, clr_err, cfg_stop2;
    logic [15:0] baud_div;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        rts_n, rd_valid, overrun;
    logic [11:0] rd_data;
    logic [4:0]  level;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] sb[$];

    typedef struct {
        logic [8:0]  d;
        logic [3:0]  nb;
        logic [1:0]  par;
        logic        st2;
        logic        pflip;
        logic        sbad;
        logic [11:0] want;
    } vec_t;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    uart_rx_os #(.OSR(OSR), .DIV_W(16), .DEPTH(16), .RTS_THRESH(12)) dut (
        .clk(clk), .rst(rst), .enable(enable), .baud_div(baud_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .rx(rx), .rts_n(rts_n), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .level(level), .overrun(overrun), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(BIT);
    endtask

    task automatic send_frame(input logic [8:0] d, input logic [3:0] nbcfg, input logic [1:0] par,
                              input logic st2, input logic pflip, input logic sbad);
        int   nb;
        logic p;
        cfg_data_bits = nbcfg;
        cfg_parity    = par;
        cfg_stop2     = st2;
        nb = (nbcfg < 4'd5) ? 5 : (nbcfg > 4'd9) ? 9 : int'(nbcfg);
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        if (par == 2'b10) p = ~p;
        p ^= pflip;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (par == 2'b01 || par == 2'b10) send_bit(p);
        send_bit(~sbad);
        if (st2) send_bit(1'b1);
    endtask

    task automatic drain_one(input string tag);
        int          t;
        logic [11:0] e;
        t = 0;
        while (!rd_valid && t < 20 * BIT) begin
            tick(1);
            t++;
        end
        if (!rd_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: rd_valid=0 required 1", tag);
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_extra: rd_data=0x%03h but no entry expected", tag, rd_data);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, rd_data, e);
            rd_ready = 1'b1;
            tick(1);
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{9'h0A5, 4'd8,  2'b00, 1'b0, 1'b0, 1'b0, 12'h0A5};
        vecs[1]  = '{9'h041, 4'd7,  2'b10, 1'b1, 1'b0, 1'b0, 12'h041};
        vecs[2]  = '{9'h041, 4'd7,  2'b10, 1'b1, 1'b1, 1'b0, 12'h241};
        vecs[3]  = '{9'h03C, 4'd8,  2'b00, 1'b0, 1'b0, 1'b1, 12'h43C};
        vecs[4]  = '{9'h1FF, 4'd9,  2'b01, 1'b0, 1'b0, 1'b0, 12'h1FF};
        vecs[5]  = '{9'h00A, 4'd3,  2'b00, 1'b0, 1'b0, 1'b0, 12'h00A};
        vecs[6]  = '{9'h1F3, 4'd8,  2'b01, 1'b0, 1'b0, 1'b0, 12'h0F3};
        vecs[7]  = '{9'h155, 4'd15, 2'b10, 1'b0, 1'b0, 1'b0, 12'h155};
        vecs[8]  = '{9'h000, 4'd8,  2'b01, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{9'h02A, 4'd6,  2'b01, 1'b1, 1'b0, 1'b1, 12'h42A};
        vecs[10] = '{9'h000, 4'd8,  2'b01, 1'b0, 1'b0, 1'b1, 12'hC00};

        rst = 1'b1; enable = 1'b1; rx = 1'b1; rd_ready = 1'b0; clr_err = 1'b0;
        baud_div = 16'd2; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tick(5);
        check("rst_rts_n", rts_n, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_level", level, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick(1);
        check("rts_n_after_rst", rts_n, 0);
        tick(BIT);

        for (int i = 0; i < NV; i++) begin
            sb.push_back(vecs[i].want);
            send_frame(vecs[i].d, vecs[i].nb, vecs[i].par, vecs[i].st2, vecs[i].pflip, vecs[i].sbad);
            check($sformatf("v%0d_valid_before_stop_end", i), rd_valid, 1);
            check($sformatf("v%0d_level", i), level, 1);
            rx = 1'b1;
            tick(BIT);
            drain_one($sformatf("v%0d", i));
            check($sformatf("v%0d_level_drained", i), level, 0);
        end

        rx = 1'b0;
        tick(6 * DIV);
        rx = 1'b1;
        tick(3 * BIT);
        check("glitch_level", level, 0);
        check("glitch_valid", rd_valid, 0);
        sb.push_back(12'h05A);
        send_frame(9'h05A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(4);
        drain_one("after_glitch");

        cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        sb.push_back(12'hC00);
        rx = 1'b0;
        tick(20 * BIT);
        check("brk_level_low", level, 1);
        rx = 1'b1;
        tick(2 * BIT);
        check("brk_level_high", level, 1);
        drain_one("brk");

        for (int k = 1; k <= 17; k++) begin
            logic [8:0] d;
            d = 9'((k * 7 + 3) & 8'hFF);
            if (k <= 16) sb.push_back({3'b000, d});
            send_frame(d, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
            tick(4);
            if (k <= 16) begin
                check($sformatf("fill%0d_level", k), level, k);
                check($sformatf("fill%0d_rts_n", k), rts_n, (k >= 12) ? 1 : 0);
                check($sformatf("fill%0d_overrun", k), overrun, 0);
            end
        end
        check("ovr_overrun", overrun, 1);
        check("ovr_level", level, 16);
        check("ovr_rts_n", rts_n, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovr_cleared", overrun, 0);
        for (int j = 1; j <= 5; j++) begin
            drain_one($sformatf("drain%0d", j));
            check($sformatf("drain%0d_rts_n", j), rts_n, ((16 - j) >= 12) ? 1 : 0);
        end
        for (int j = 6; j <= 16; j++) drain_one($sformatf("drain%0d", j));
        check("drained_valid", rd_valid, 0);

        sb.push_back(12'h011);
        sb.push_back(12'h022);
        send_frame(9'h011, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
        send_frame(9'h022, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(4);
        check("mid_rst_level_before", level, 2);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        check("mid_rst_rts_n", rts_n, 1);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_overrun", overrun, 0);
        sb.delete();
        rst = 1'b0;
        tick(2 * BIT);
        check("post_rst_level", level, 0);
        sb.push_back(12'h055);
        send_frame(9'h055, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(4);
        drain_one("post_rst");
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised next-generation UART receiver for the COMM/UART family. It has:
- a programmable oversampling baud-tick generator;
- a 2-flop input synchroniser and 3-sample majority voting;
- run-time data width (5-9), parity and stop-bit selection;
- a show-ahead FIFO that stores error flags per entry;
- break detection and threshold-based RTS flow control.

It sits between the pad-side rx line and the register block's read-data path.

Parameters:
OSR, 16, oversample ticks per bit; even, 8..32
DIV_W, 16, width of baud_div
DEPTH, 16, FIFO entries; power of 2, >=2
RTS_THRESH, 12, FIFO level at which rts_n deasserts; 1..DEPTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  receiver enable
baud_div  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
cfg_data_bits  in  4  data bits per frame; <5 clamps to 5, >9 clamps to 9
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  in  1  1 = two stop bits checked
rx  in  1  asynchronous serial line, idle high
rts_n  out  1  0 = peer may send
rd_data  out  12  {break, frame_err, parity_err, data[8:0]} at FIFO head
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  pop when rd_valid & rd_ready
level  out  $clog2(DEPTH+1)  FIFO occupancy
overrun  out  1  sticky; a frame was dropped because the FIFO was full
clr_err  in  1  clears overrun (single-cycle pulse)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All state updates on posedge clk.
- Reset values: rts_n=1, rd_valid=0, rd_data=0, level=0, overrun=0. Synchroniser flops reset to 1. FSM resets to IDLE; tick and sample counters reset to 0.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied. rts_n goes to 0 on the first cycle after rst falls.

Tick generator:
- Counter runs 0..max(baud_div,1)-1; os_tick pulses for 1 cycle on wrap.
- Counter runs continuously, independent of enable.
- A new baud_div value takes effect at the next wrap.

FSM, advancing only on os_tick:
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- Sample counter s counts 0..OSR-1. Bit value is the majority of the synced samples at s = OSR/2-1, OSR/2, OSR/2+1, decided at s = OSR/2+1.
- IDLE: on synced rx=0, clear s and go to START.
- START: majority 1 -> false start, return to IDLE with no push. Majority 0 -> go to DATA at s=OSR-1.
- DATA: shift bits in LSB first. After N bits, go to PARITY if parity is enabled, else STOP. Data bits above N are stored as 0.
- PARITY: even parity requires XOR(data, p) = 0; odd parity requires 1. Mismatch sets parity_err for the frame.
- STOP: a sample of 0 sets frame_err. With cfg_stop2, a second stop bit is checked and either failing bit flags frame_err.
- Push happens on the cycle the last stop-bit majority is decided. The stop bit's remaining half-bit is not waited out.
- Break: all data bits 0, parity bit (if present) 0 and first stop bit 0. Sets break and frame_err; after the push, go to BRK_WAIT. BRK_WAIT returns to IDLE on the first os_tick with synced rx=1.
- Otherwise the FSM returns to IDLE after the push.
- enable=0: FSM forced to IDLE and any in-progress frame discarded. FIFO and overrun are retained.
- cfg_* are sampled at the START-to-DATA transition and held for the rest of the frame.

FIFO:
- Show-ahead: rd_data is valid whenever rd_valid=1.
- Push and pop in the same cycle: level unchanged, including when full (the push is accepted and overrun is not set) and when empty (rd_valid stays 0 that cycle; data appears next cycle).
- Push while full without a pop: frame dropped and overrun set to 1. overrun holds until clr_err.
- clr_err coinciding with a new overrun event: the set wins.
- Read and write pointers wrap modulo DEPTH.
- rd_data holds its last value when the FIFO is empty.

rts_n:
- Registered. rts_n = (level_next >= RTS_THRESH).
- Asserts and deasserts one cycle after the level change.

Latency: push to rd_valid=1 is 1 cycle.

Test Plan:
- baud_div=2, OSR=16 (32 clk/bit), 8N1, frame 0xA5 -> one entry 0x0A5 with all flags 0. rd_valid rises 1 cycle after the stop-bit mid-sample; level=1.
- 7 data bits, odd parity, 2 stop bits, data 0x41 with correct parity bit 1 -> rd_data=0x041. Same frame with parity bit 0 -> parity_err=1, data 0x041.
- 6-tick glitch low on idle line -> START majority 1, no push, FSM back in IDLE, level=0.
- 8N1 with stop bit driven 0 (data 0x3C) -> frame_err=1, break=0. Line held low for 20 bits -> single entry with break=1, frame_err=1, data 0. No further pushes until rx=1.
- DEPTH=16, RTS_THRESH=12, rd_ready=0, send 17 frames -> rts_n=1 from the 12th push. The 17th frame is dropped and overrun=1; clr_err clears it. Draining 5 entries -> rts_n=0 once level=11.
- Assert rst mid-DATA of the 3rd frame with 2 entries queued -> next cycle all outputs at reset values. The following clean frame 0x55 is received correctly.
